mem_bus_arb: RTL

MEM_BUS_ARB -- requirements
Module: mem_bus_arb

---
 rtl/mem_bus_arb.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_bus_arb.sv
// Two-port arbiter in front of a single synchronous-read memory. Port 0 is the
// processor, port 1 is external/DMA; a bounded hold count keeps either port from starving the other.
module mem_bus_arb #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned MAX_HOLD  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 boot,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [WORD_SIZE-1:0] wdata0,
  input  logic [WORD_SIZE-1:0] wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [WORD_SIZE-1:0] rdata,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 mem_we,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  localparam logic [3:0] HoldMax = 4'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic       last_q, last_d;
  logic       rvalid0_q, rvalid1_q;
  logic       own_req, oth_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
      rvalid0_q <= gnt0 & req0 & ~we0;
      rvalid1_q <= gnt1 & req1 & ~we1;
    end
  end

  always_comb begin
    state_d = state_q;
    own_req = 1'b0;
    oth_req = 1'b0;
    case (state_q)
      StOwn0: begin
        own_req = req0;
        oth_req = req1;
      end
      StOwn1: begin
        own_req = req1;
        oth_req = req0;
      end
      default: ;
    endcase

    if (boot) begin
      state_d = req0 ? StOwn0 : StIdle;
    end else if (state_q != StIdle) begin
      if (own_req && (!oth_req || hold_q < HoldMax)) begin
        state_d = state_q;
      end else if (oth_req) begin
        state_d = (state_q == StOwn0) ? StOwn1 : StOwn0;
      end else begin
        state_d = StIdle;
      end
    end else if (req0 && req1) begin
      // Round-robin from idle: whoever did not own last goes first.
      state_d = last_q ? StOwn0 : StOwn1;
    end else if (req0) begin
      state_d = StOwn0;
    end else if (req1) begin
      state_d = StOwn1;
    end else begin
      state_d = StIdle;
    end

    // Clearing under boot guarantees a fresh hold window once boot falls.
    hold_d = hold_q;
    if (boot || state_d != state_q || state_d == StIdle) begin
      hold_d = '0;
    end else if (oth_req && hold_q < HoldMax) begin
      hold_d = hold_q + 4'd1;
    end

    last_d = last_q;
    if (state_d == StOwn0) begin
      last_d = 1'b0;
    end else if (state_d == StOwn1) begin
      last_d = 1'b1;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (state_q)
      StOwn0: begin
        mem_addr  = addr0;
        mem_wdata = wdata0;
        mem_we    = we0 & req0;
      end
      StOwn1: begin
        mem_addr  = addr1;
        mem_wdata = wdata1;
        mem_we    = we1 & req1;
      end
      default: ;
    endcase
  end

  assign gnt0    = (state_q == StOwn0);
  assign gnt1    = (state_q == StOwn1);
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  // Memory data is only meaningful the cycle after a granted read.
  assign rdata   = (rvalid0_q | rvalid1_q) ? mem_rdata : '0;

endmodule
